if_stage_pc_control: RTL and testbench
======================================

# if_stage_pc_control

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. It consumes the stall controls from hazard detection (`PCWrite`, `IF_ID_Write`) and the branch redirect from the EX/MEM stage. On a taken branch it flushes IF/ID to a NOP bubble. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `XLEN`, 64: width of the PC and the branch target.
- `RESET_PC`, 0: PC value loaded on reset.
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PCWrite`  in  1  from hazard detection; 1 = PC may advance, 0 = hold PC.
- `IF_ID_Write`  in  1  from hazard detection; 1 = IF/ID may load, 0 = hold IF/ID.
- `branch_taken`  in  1  redirect request from EX/MEM.
- `branch_target`  in  XLEN  redirect address.
- `imem_addr`  out  XLEN  instruction-memory address; combinationally equal to PC.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `IF_ID_PC`  out  XLEN  PC of the instruction held in IF/ID.
- `IF_ID_Instr`  out  32  instruction held in IF/ID.
- `IF_ID_Valid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- `stall_count`  out  CNT_W  count of stalled cycles.
- `flush_count`  out  CNT_W  count of taken redirects.

## Operation
- Reset values:
  - PC = `RESET_PC`.
  - `IF_ID_PC` = 0.
  - `IF_ID_Instr` = 32'h00000013 (addi x0,x0,0).
  - `IF_ID_Valid` = 0.
  - Both counters = 0.
- Reset overrides every other input.
- PC update, in priority order:
  1. `branch_taken`: PC <= {`branch_target`[XLEN-1:2], 2'b00}. The low two bits are always cleared. The redirect overrides `PCWrite`=0.
  2. Else if `PCWrite`: PC <= PC + 4, modulo 2^XLEN. PC wraps from all-ones-minus-3 to 0.
  3. Else: hold.
- IF/ID update, in priority order:
  1. `branch_taken`: flush. `IF_ID_Instr` <= NOP, `IF_ID_Valid` <= 0, `IF_ID_PC` <= 0. The flush overrides `IF_ID_Write`=0.
  2. Else if `IF_ID_Write`: `IF_ID_PC` <= PC, `IF_ID_Instr` <= `imem_rdata`, `IF_ID_Valid` <= 1.
  3. Else: hold all three fields unchanged.
- `PCWrite` and `IF_ID_Write` are honoured independently. If they disagree, each register obeys its own enable; no error is raised.
- `stall_count`: +1 on each cycle with `IF_ID_Write`=0 and `branch_taken`=0. Saturates at 2^CNT_W-1.
- `flush_count`: +1 on each cycle with `branch_taken`=1. Saturates at 2^CNT_W-1.
- No state machine beyond these registers. Behaviour is a pure function of current state and inputs each cycle.

## Timing
- `imem_addr` follows PC with zero latency (combinational).
- Fetch-to-IF/ID latency is 1 cycle. The word at PC in cycle N appears on `IF_ID_Instr` in cycle N+1, tagged with `IF_ID_PC` = that PC.
- Redirect:
  - `branch_taken` in cycle N puts `branch_target` on `imem_addr` in cycle N+1.
  - IF/ID shows a bubble in cycle N+1.
  - The target instruction is valid in IF/ID in cycle N+2, provided `IF_ID_Write`=1 in cycle N+1.
- Stall: with `PCWrite`=`IF_ID_Write`=0 in cycle N, PC and IF/ID in cycle N+1 equal their cycle-N values. Each further stall cycle holds them again.
- The first valid instruction after reset deassertion reaches IF/ID one cycle after `reset` drops.
- `reset` asserted mid-stall or mid-redirect: reset values appear on the next edge, regardless of other inputs.
- Counters update on the same edge as the event they count.

## Test plan
- **Reset and sequential fetch.** Hold `reset` for 2 cycles with `RESET_PC`=0, then release with `PCWrite`=`IF_ID_Write`=1.
  - Required: `imem_addr` = 0, 4, 8, 12 on successive cycles.
  - Required: `IF_ID_PC` lags `imem_addr` by one cycle, with `IF_ID_Valid` = 1 from the second cycle after release.
- **Load-use stall.** From PC=0x10, drive `PCWrite`=`IF_ID_Write`=0 for 1 cycle.
  - Required: PC stays 0x10 and IF/ID holds PC 0x0C with its instruction.
  - Required: `stall_count` = 1.
  - Required: fetch resumes at 0x14 after the stall.
- **Redirect during stall.** `branch_taken`=1, `branch_target`=0x103, with `PCWrite`=`IF_ID_Write`=0.
  - Required on the next cycle: `imem_addr` = 0x100, `IF_ID_Valid` = 0, `IF_ID_Instr` = 0x00000013.
  - Required: `flush_count` +1 and `stall_count` unchanged.
- **Split enables.** `PCWrite`=1, `IF_ID_Write`=0 for 1 cycle.
  - Required: PC advances by 4 while IF/ID holds its contents.
  - Required: `stall_count` +1.
- **PC wrap.** Redirect to 0xFFFF_FFFF_FFFF_FFFC, then advance.
  - Required: `imem_addr` = 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
- **Counter saturation and reset.** With `CNT_W`=4, stall for 20 cycles.
  - Required: `stall_count` stops at 15.
  - Then assert `reset` for 1 cycle. Required: both counters = 0 and PC = `RESET_PC`.

Source files
------------

// File: rtl/if_stage_pc_control.sv
// Instruction-fetch stage: program counter, instruction-memory address, IF/ID
// pipeline register, and saturating stall/flush counters for performance debug.
module if_stage_pc_control #(
    parameter int unsigned         XLEN     = 64,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int unsigned         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  IF_ID_PC,
    output logic [31:0]      IF_ID_Instr,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // addi x0, x0, 0
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Redirect targets are forced word-aligned, so the low bits are ignored.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target[1:0];

    // PC next state: redirect beats the stall, otherwise advance or hold.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = {branch_target[XLEN-1:2], 2'b00};
        end else if (PCWrite) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // IF/ID next state: a taken branch flushes to a bubble even while stalled.
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (branch_taken) begin
            ifid_pc_d    = '0;
            ifid_instr_d = Nop;
            ifid_valid_d = 1'b0;
        end else if (IF_ID_Write) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
        end
    end

    // Saturating performance counters; a flush cycle is not counted as a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!IF_ID_Write && !branch_taken && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= Nop;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign IF_ID_PC    = ifid_pc_q;
    assign IF_ID_Instr = ifid_instr_q;
    assign IF_ID_Valid = ifid_valid_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_if_stage_pc_control.sv
// Bench for if_stage_pc_control: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the fetch stage.
module tb_if_stage_pc_control;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 4;
    localparam logic [3:0]  CMAX  = 4'd15;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic [XLEN-1:0]  IF_ID_PC;
    logic [31:0]      IF_ID_Instr;
    logic             IF_ID_Valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [63:0] m_pc, m_ifid_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [3:0]  m_stall, m_flush;

    if_stage_pc_control #(
        .XLEN     (XLEN),
        .RESET_PC (64'h0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Drive one cycle of inputs, advance the model, and sample 1 time unit after the edge.
    task automatic step(input logic r, input logic pcw, input logic ifw, input logic bt,
                        input logic [63:0] tgt);
        logic [63:0] n_pc, n_ifid_pc;
        logic [31:0] n_instr;
        logic        n_valid;
        logic [3:0]  n_stall, n_flush;
        reset = r; PCWrite = pcw; IF_ID_Write = ifw; branch_taken = bt; branch_target = tgt;
        if (r) begin
            n_pc = 64'h0; n_ifid_pc = 64'h0; n_instr = NOP; n_valid = 1'b0;
            n_stall = 4'd0; n_flush = 4'd0;
        end else begin
            n_pc = bt ? (tgt & ~64'h3) : (pcw ? m_pc + 64'd4 : m_pc);
            if (bt) begin
                n_ifid_pc = 64'h0; n_instr = NOP; n_valid = 1'b0;
            end else if (ifw) begin
                n_ifid_pc = m_pc; n_instr = mem_word(m_pc); n_valid = 1'b1;
            end else begin
                n_ifid_pc = m_ifid_pc; n_instr = m_instr; n_valid = m_valid;
            end
            n_stall = (!ifw && !bt && m_stall < CMAX) ? m_stall + 4'd1 : m_stall;
            n_flush = (bt && m_flush < CMAX) ? m_flush + 4'd1 : m_flush;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ifid_pc = n_ifid_pc; m_instr = n_instr; m_valid = n_valid;
        m_stall = n_stall; m_flush = n_flush;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 64'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        tests_run += 4;
        if (imem_addr !== 64'h0) begin
            tests_failed++; $display("FAIL reset_pc: got %h expected 0", imem_addr);
        end
        if (IF_ID_Valid !== 1'b0 || IF_ID_PC !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_ifid: got valid=%b pc=%h expected 0/0", IF_ID_Valid, IF_ID_PC);
        end
        if (IF_ID_Instr !== NOP) begin
            tests_failed++; $display("FAIL reset_instr: got %h expected %h", IF_ID_Instr, NOP);
        end
        if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_seq_fetch();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (imem_addr !== 64'(i * 4)) begin
                tests_failed++; $display("FAIL seq_addr: got %h expected %h", imem_addr, i * 4);
            end
            step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
            tests_run++;
            if (IF_ID_PC !== 64'(i * 4) || IF_ID_Valid !== 1'b1 ||
                IF_ID_Instr !== mem_word(64'(i * 4))) begin
                tests_failed++;
                $display("FAIL seq_ifid: got pc=%h v=%b ins=%h expected pc=%h v=1 ins=%h",
                         IF_ID_PC, IF_ID_Valid, IF_ID_Instr, i * 4, mem_word(64'(i * 4)));
            end
        end
    endtask

    task automatic test_load_use();
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        tests_run += 3;
        if (imem_addr !== 64'h10) begin
            tests_failed++; $display("FAIL stall_pc: got %h expected 10", imem_addr);
        end
        if (IF_ID_PC !== 64'hC || IF_ID_Instr !== mem_word(64'hC) || IF_ID_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_ifid: got pc=%h ins=%h expected pc=c ins=%h",
                     IF_ID_PC, IF_ID_Instr, mem_word(64'hC));
        end
        if (stall_count !== 4'd1) begin
            tests_failed++; $display("FAIL stall_cnt: got %0d expected 1", stall_count);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        tests_run++;
        if (imem_addr !== 64'h14 || IF_ID_PC !== 64'h10) begin
            tests_failed++;
            $display("FAIL stall_resume: got addr=%h ifpc=%h expected 14/10", imem_addr, IF_ID_PC);
        end
    endtask

    task automatic test_redirect_stall();
        logic [3:0] s0, f0;
        s0 = m_stall; f0 = m_flush;
        step(1'b0, 1'b0, 1'b0, 1'b1, 64'h103);
        tests_run += 3;
        if (imem_addr !== 64'h100) begin
            tests_failed++; $display("FAIL redir_addr: got %h expected 100", imem_addr);
        end
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== NOP) begin
            tests_failed++;
            $display("FAIL redir_bubble: got v=%b ins=%h expected 0/%h", IF_ID_Valid, IF_ID_Instr, NOP);
        end
        if (flush_count !== f0 + 4'd1 || stall_count !== s0) begin
            tests_failed++;
            $display("FAIL redir_cnt: got f=%0d s=%0d expected f=%0d s=%0d",
                     flush_count, stall_count, f0 + 4'd1, s0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        tests_run++;
        if (IF_ID_PC !== 64'h100 || IF_ID_Valid !== 1'b1 || imem_addr !== 64'h104) begin
            tests_failed++;
            $display("FAIL redir_target: got ifpc=%h v=%b addr=%h expected 100/1/104",
                     IF_ID_PC, IF_ID_Valid, imem_addr);
        end
    endtask

    task automatic test_split_enables();
        logic [3:0] s0;
        s0 = m_stall;
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        tests_run += 2;
        if (imem_addr !== 64'h108 || IF_ID_PC !== 64'h100 || IF_ID_Instr !== mem_word(64'h100)) begin
            tests_failed++;
            $display("FAIL split_hold: got addr=%h ifpc=%h expected 108/100", imem_addr, IF_ID_PC);
        end
        if (stall_count !== s0 + 4'd1) begin
            tests_failed++; $display("FAIL split_cnt: got %0d expected %0d", stall_count, s0 + 4'd1);
        end
    endtask

    task automatic test_pc_wrap();
        step(1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        tests_run++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            tests_failed++; $display("FAIL wrap_top: got %h expected fffffffffffffffc", imem_addr);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        tests_run++;
        if (imem_addr !== 64'h0 || IF_ID_PC !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_zero: got addr=%h ifpc=%h expected 0/fffffffffffffffc",
                     imem_addr, IF_ID_PC);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        tests_run++;
        if (stall_count !== 4'd15) begin
            tests_failed++; $display("FAIL sat_stall: got %0d expected 15", stall_count);
        end
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 64'h40);
        tests_run++;
        if (flush_count !== 4'd15) begin
            tests_failed++; $display("FAIL sat_flush: got %0d expected 15", flush_count);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 64'h80);
        tests_run++;
        if (stall_count !== 4'd0 || flush_count !== 4'd0 || imem_addr !== 64'h0) begin
            tests_failed++;
            $display("FAIL sat_reset: got s=%0d f=%0d addr=%h expected 0/0/0",
                     stall_count, flush_count, imem_addr);
        end
    endtask

    task automatic test_random();
        logic r, pcw, ifw, bt;
        logic [63:0] tgt;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            pcw = ($urandom_range(0, 3) != 0);
            ifw = ($urandom_range(0, 3) != 0);
            bt  = ($urandom_range(0, 5) == 0);
            tgt = {$urandom, $urandom};
            step(r, pcw, ifw, bt, tgt);
            tests_run++;
            if (imem_addr !== m_pc || IF_ID_PC !== m_ifid_pc || IF_ID_Instr !== m_instr ||
                IF_ID_Valid !== m_valid || stall_count !== m_stall || flush_count !== m_flush) begin
                tests_failed++;
                $display("FAIL rand[%0d]: got pc=%h ifpc=%h ins=%h v=%b s=%0d f=%0d expected pc=%h ifpc=%h ins=%h v=%b s=%0d f=%0d",
                         i, imem_addr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid, stall_count, flush_count,
                         m_pc, m_ifid_pc, m_instr, m_valid, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0; branch_taken = 1'b0;
        branch_target = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_seq_fetch();
        test_load_use();
        test_redirect_stall();
        test_split_enables();
        test_pc_wrap();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
